// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state
// encoding and elaboration-time helpers for slice geometry.
package cmp_pkg;

   // FSM state encoding; exported on the comparator's state_o debug port
   typedef enum logic [1:0] {
      CMP_IDLE = 2'd0,
      CMP_RUN  = 2'd1,
      CMP_DONE = 2'd2
   } cmp_state_t;

   // Number of slices (worst-case compare cycles) for an operand width
   function automatic int nslice(input int width, input int slice);
      return width / slice;
   endfunction

   // True when the operand width splits evenly into slices
   function automatic bit slice_fits(input int width, input int slice);
      return (slice > 0) && (width % slice == 0);
   endfunction

   // Slice counter width: $clog2(NSLICE), never less than one bit
   function automatic int cnt_width(input int ns);
      return (ns > 1) ? $clog2(ns) : 1;
   endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational W-bit unsigned magnitude comparator. Exactly one of
// eq/gt/lt is high for any pair of inputs.
module cmp_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq,
   output logic         gt,
   output logic         lt
);

   assign eq = (a == b);
   assign gt = (a > b);
   assign lt = (a < b);

endmodule

// File: rtl/mag_cmp_serial.sv
// Multi-cycle magnitude comparator. Operands are captured on the accepting
// edge and compared MSB-first, SLICE bits per clock, stopping at the first
// slice that differs. Signed compares flip both sign bits on load so the
// plain unsigned slice compare yields two's-complement order.
//
// Handshake: start_i is a request that is accepted on a rising edge only
// when the FSM is in IDLE or DONE (busy_o=0); A_i/B_i are sampled on that
// edge alone. busy_o is high for every cycle of the compare and start_i is
// ignored meanwhile. done_o pulses for exactly one cycle, after which
// eq_o/gt_o/lt_o hold until the next accepting edge clears them. Holding
// start_i during the done_o cycle starts the next compare with no idle gap.
module mag_cmp_serial
   import cmp_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int SLICE  = 4,
   parameter int SIGNED = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             eq_o,
   output logic             gt_o,
   output logic             lt_o,
   output logic [1:0]       state_o
);

   localparam int NSLICE = nslice(WIDTH, SLICE);
   localparam int CNT_W  = cnt_width(NSLICE);
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NSLICE - 1);
   localparam logic [WIDTH-1:0] SIGN_MASK =
      (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

   if (!slice_fits(WIDTH, SLICE)) begin : g_bad_geometry
      $error("mag_cmp_serial: WIDTH must be a positive multiple of SLICE");
   end

   cmp_state_t       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CNT_W-1:0] cnt;
   logic             s_eq;
   logic             s_gt;
   logic             s_lt;

   // Compare the current top slices of both shift registers
   cmp_slice #(.W(SLICE)) u_slice (
      .a  (a_sh[WIDTH-1 -: SLICE]),
      .b  (b_sh[WIDTH-1 -: SLICE]),
      .eq (s_eq),
      .gt (s_gt),
      .lt (s_lt)
   );

   // Status outputs decode straight from the state register
   assign busy_o  = (state == CMP_RUN);
   assign done_o  = (state == CMP_DONE);
   assign state_o = state;

   // FSM, operand shifting, slice counting and result capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= CMP_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         cnt   <= '0;
         eq_o  <= 1'b0;
         gt_o  <= 1'b0;
         lt_o  <= 1'b0;
      end else begin
         case (state)
            CMP_IDLE, CMP_DONE: begin
               if (start_i) begin
                  a_sh  <= A_i ^ SIGN_MASK;
                  b_sh  <= B_i ^ SIGN_MASK;
                  cnt   <= '0;
                  eq_o  <= 1'b0;
                  gt_o  <= 1'b0;
                  lt_o  <= 1'b0;
                  state <= CMP_RUN;
               end else begin
                  state <= CMP_IDLE;
               end
            end
            CMP_RUN: begin
               if (!s_eq) begin
                  gt_o  <= s_gt;
                  lt_o  <= s_lt;
                  state <= CMP_DONE;
               end else if (cnt == LAST_K) begin
                  eq_o  <= 1'b1;
                  state <= CMP_DONE;
               end else begin
                  a_sh <= a_sh << SLICE;
                  b_sh <= b_sh << SLICE;
                  cnt  <= cnt + CNT_W'(1);
               end
            end
            default: state <= CMP_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mag_cmp_serial.sv
// Bench for mag_cmp_serial: three instances (unsigned 16/4, signed 16/4,
// unsigned 16/16) share operand buses; each has its own start line.
module tb_mag_cmp_serial;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [2:0]  start_v = '0;
   logic [15:0] a_v = '0;
   logic [15:0] b_v = '0;
   logic [2:0]  busy, done, eq, gt, lt;
   logic [1:0]  st [3];

   int passed = 0;
   int total  = 0;
   logic [10:0] exp_q[$];   // {eq, gt, lt, latency[7:0]}

   mag_cmp_serial #(.WIDTH(16), .SLICE(4), .SIGNED(0)) u_uns (
      .clk_i(clk), .rst_i(rst), .start_i(start_v[0]), .A_i(a_v), .B_i(b_v),
      .busy_o(busy[0]), .done_o(done[0]), .eq_o(eq[0]), .gt_o(gt[0]),
      .lt_o(lt[0]), .state_o(st[0]));

   mag_cmp_serial #(.WIDTH(16), .SLICE(4), .SIGNED(1)) u_sgn (
      .clk_i(clk), .rst_i(rst), .start_i(start_v[1]), .A_i(a_v), .B_i(b_v),
      .busy_o(busy[1]), .done_o(done[1]), .eq_o(eq[1]), .gt_o(gt[1]),
      .lt_o(lt[1]), .state_o(st[1]));

   mag_cmp_serial #(.WIDTH(16), .SLICE(16), .SIGNED(0)) u_wide (
      .clk_i(clk), .rst_i(rst), .start_i(start_v[2]), .A_i(a_v), .B_i(b_v),
      .busy_o(busy[2]), .done_o(done[2]), .eq_o(eq[2]), .gt_o(gt[2]),
      .lt_o(lt[2]), .state_o(st[2]));

   // Reference: full-width compare plus first-differing-slice latency
   function automatic logic [10:0] model(input int sel, input logic [15:0] a,
                                         input logic [15:0] b);
      int sl, ns, d;
      logic [31:0] x;
      logic e, g, l;
      sl = (sel == 2) ? 16 : 4;
      ns = 16 / sl;
      d  = ns;
      x  = {16'h0, a ^ b};
      for (int k = ns - 1; k >= 0; k--)
         if (((x >> (16 - sl * (k + 1))) & ((32'd1 << sl) - 32'd1)) != 0) d = k + 1;
      e = (a == b);
      if (sel == 1) begin
         g = $signed(a) > $signed(b);
         l = $signed(a) < $signed(b);
      end else begin
         g = a > b;
         l = a < b;
      end
      return {e, g, l, 8'(d)};
   endfunction

   // ---------------- driver tasks ----------------
   // Present operands and start; returns #1 after the accepting edge (edge 0)
   task automatic drive_start(input int sel, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      a_v = a;
      b_v = b;
      start_v = '0;
      start_v[sel] = 1'b1;
      @(posedge clk);
      #1;
      start_v = '0;
   endtask

   // Count edges until done is seen; lat = -1 if the budget runs out
   task automatic wait_done(input int sel, input int from_edge, output int lat);
      lat = -1;
      for (int e = from_edge + 1; e <= from_edge + 40; e++) begin
         @(posedge clk);
         #1;
         if (done[sel]) begin
            lat = e;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         total++;
         if ({busy[s], done[s], eq[s], gt[s], lt[s], st[s]} !== 7'b0)
            $display("FAIL reset[%0d]: busy/done/eq/gt/lt/state=%b want 0000000",
                     s, {busy[s], done[s], eq[s], gt[s], lt[s], st[s]});
         else passed++;
      end
      rst = 1'b0;
   endtask

   // Directed compares with hand-derived results and latencies
   task automatic test_directed;
      int          sel_t [8] = '{0, 0, 0, 0, 1, 1, 1, 2};
      logic [15:0] a_t   [8] = '{16'h0000, 16'hF000, 16'h1232, 16'h1240,
                                 16'hF000, 16'h8000, 16'hFFFF, 16'h0000};
      logic [15:0] b_t   [8] = '{16'h0000, 16'h0FFF, 16'h1233, 16'h1233,
                                 16'h0FFF, 16'h0001, 16'hFFFE, 16'h0000};
      logic [10:0] r_t   [8] = '{11'h404, 11'h201, 11'h104, 11'h203,
                                 11'h101, 11'h101, 11'h204, 11'h401};
      int lat;
      logic [10:0] got, want;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(r_t[i]);
         drive_start(sel_t[i], a_t[i], b_t[i]);
         total++;
         if (busy[sel_t[i]] !== 1'b1)
            $display("FAIL busy_after_accept[%0d]: busy=%b want 1", i, busy[sel_t[i]]);
         else passed++;
         wait_done(sel_t[i], 0, lat);
         got  = {eq[sel_t[i]], gt[sel_t[i]], lt[sel_t[i]], 8'(lat)};
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            $display("FAIL directed[%0d] a=%h b=%h: eq/gt/lt/lat=%h want %h",
                     i, a_t[i], b_t[i], got, want);
         else passed++;
         // one cycle later: pulse gone, results held, back in IDLE
         @(posedge clk);
         #1;
         total++;
         if ({done[sel_t[i]], eq[sel_t[i]], gt[sel_t[i]], lt[sel_t[i]], st[sel_t[i]]}
             !== {1'b0, want[10:8], 2'd0})
            $display("FAIL hold[%0d]: done/eq/gt/lt/state=%b want %b", i,
                     {done[sel_t[i]], eq[sel_t[i]], gt[sel_t[i]], lt[sel_t[i]], st[sel_t[i]]},
                     {1'b0, want[10:8], 2'd0});
         else passed++;
      end
   endtask

   // start while busy must not resample operands or disturb the result
   task automatic test_ignore_start;
      int lat;
      logic [10:0] got, want;
      exp_q.push_back(11'h404);
      drive_start(0, 16'h1111, 16'h1111);
      @(posedge clk);              // edge 1
      @(negedge clk);
      a_v = 16'h0000;
      start_v[0] = 1'b1;
      @(posedge clk);              // edge 2
      #1;
      start_v = '0;
      total++;
      if (busy[0] !== 1'b1) $display("FAIL ignore_busy: busy=%b want 1", busy[0]);
      else passed++;
      wait_done(0, 2, lat);
      got  = {eq[0], gt[0], lt[0], 8'(lat)};
      want = exp_q.pop_front();
      total++;
      if (got !== want) $display("FAIL ignore_start: eq/gt/lt/lat=%h want %h", got, want);
      else passed++;
      @(posedge clk);
      #1;
   endtask

   // reset mid-compare aborts with no done pulse
   task automatic test_reset_abort;
      int ndone = 0;
      drive_start(0, 16'h1111, 16'h1111);
      @(posedge clk);              // edge 1
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);              // edge 2
      #1;
      rst = 1'b0;
      total++;
      if ({busy[0], done[0], eq[0], gt[0], lt[0], st[0]} !== 7'b0)
         $display("FAIL reset_abort: busy/done/eq/gt/lt/state=%b want 0000000",
                  {busy[0], done[0], eq[0], gt[0], lt[0], st[0]});
      else passed++;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (done[0]) ndone++;
      end
      total++;
      if (ndone !== 0) $display("FAIL reset_no_done: done pulses=%0d want 0", ndone);
      else passed++;
   endtask

   // start held in the DONE cycle launches the next compare immediately
   task automatic test_back_to_back;
      int lat;
      logic [10:0] got, want;
      exp_q.push_back(11'h201);
      drive_start(0, 16'hF000, 16'h0FFF);
      wait_done(0, 0, lat);
      got  = {eq[0], gt[0], lt[0], 8'(lat)};
      want = exp_q.pop_front();
      total++;
      if (got !== want) $display("FAIL b2b_first: eq/gt/lt/lat=%h want %h", got, want);
      else passed++;
      exp_q.push_back(11'h204);
      drive_start(0, 16'h0002, 16'h0001);   // accepted on the edge ending DONE
      total++;
      if ({busy[0], done[0], eq[0], gt[0], lt[0], st[0]} !== 7'b1000001)
         $display("FAIL b2b_accept: busy/done/eq/gt/lt/state=%b want 1000001",
                  {busy[0], done[0], eq[0], gt[0], lt[0], st[0]});
      else passed++;
      wait_done(0, 0, lat);
      got  = {eq[0], gt[0], lt[0], 8'(lat)};
      want = exp_q.pop_front();
      total++;
      if (got !== want) $display("FAIL b2b_second: eq/gt/lt/lat=%h want %h", got, want);
      else passed++;
      @(posedge clk);
      #1;
   endtask

   // random operands, often sharing upper slices, checked against the model
   task automatic test_random;
      int sel, lat;
      logic [15:0] a, b;
      logic [10:0] got, want;
      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 2);
         a   = 16'($urandom_range(0, 65535));
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = 16'($urandom_range(0, 65535));
            default: b = a ^ (16'h1 << $urandom_range(0, 15));
         endcase
         exp_q.push_back(model(sel, a, b));
         drive_start(sel, a, b);
         wait_done(sel, 0, lat);
         got  = {eq[sel], gt[sel], lt[sel], 8'(lat)};
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            $display("FAIL random[%0d] sel=%0d a=%h b=%h: eq/gt/lt/lat=%h want %h",
                     i, sel, a, b, got, want);
         else passed++;
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      total++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
